// File: rtl/riscv_lsu.sv
// Load/store unit: steers store bytes onto a req/gnt/rvalid bus, then extracts and extends
// load data. Reports misaligned or illegal accesses and bus timeouts as error responses.
module riscv_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  rsp_valid_o,
    output logic                  rsp_err_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [31:0]           mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_e        state;
    logic [CW-1:0] cnt;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [1:0]    off_q;

    logic          misaligned;
    logic          expired;
    logic [3:0]    be_n;
    logic [31:0]   wdata_n;
    logic [31:0]   shifted;
    logic [31:0]   load_ext;

    always_comb begin
        misaligned = (req_size_i == 2'b11) ||
                     (req_size_i == 2'b01 && req_addr_i[0]) ||
                     (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);
        case (req_size_i)
            2'b00:   begin be_n = 4'b0001 << req_addr_i[1:0]; wdata_n = {4{req_wdata_i[7:0]}}; end
            2'b01:   begin be_n = 4'b0011 << req_addr_i[1:0]; wdata_n = {2{req_wdata_i[15:0]}}; end
            default: begin be_n = 4'b1111;                    wdata_n = req_wdata_i; end
        endcase
    end

    // Shift the addressed lane down to bit 0, then extend from its top bit.
    always_comb begin
        shifted = mem_rdata_i >> {off_q, 3'b000};
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: load_ext = mem_rdata_i;
        endcase
    end

    assign expired = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        if (misaligned) begin
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                        end else begin
                            size_q      <= req_size_i;
                            uns_q       <= req_unsigned_i;
                            off_q       <= req_addr_i[1:0];
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= req_we_i;
                            mem_be_o    <= be_n;
                            mem_addr_o  <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
                            mem_wdata_o <= wdata_n;
                            cnt         <= '0;
                            req_ready_o <= 1'b0;
                            state       <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        cnt       <= '0;
                        if (mem_we_o) begin
                            rsp_valid_o <= 1'b1;
                            req_ready_o <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (expired) begin
                        mem_req_o   <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        req_ready_o <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= load_ext;
                        req_ready_o <= 1'b1;
                        state       <= IDLE;
                    end else if (expired) begin
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        req_ready_o <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    req_ready_o <= 1'b1;
                    mem_req_o   <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: directed and random accesses against an arithmetic reference model.
module tb_riscv_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int total = 0;
    int bad = 0;

    riscv_lsu #(.ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_err_o(rsp_err), .rsp_rdata_o(rsp_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit legal(input logic [1:0] size, input logic [31:0] addr);
        int off = int'(addr % 4);
        if (size == 2'd3) return 0;
        if (size == 2'd1) return (off % 2) == 0;
        if (size == 2'd2) return off == 0;
        return 1;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
        int off = int'(addr % 4);
        if (size == 2'd0) return 4'(1 << off);
        if (size == 2'd1) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] size, input logic [31:0] wd);
        if (size == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
        if (size == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_rd(input logic [1:0] size, input bit uns,
                                         input logic [31:0] addr, input logic [31:0] rd);
        int off = int'(addr % 4);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = (rd >> (8 * off)) & 32'hFF;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (rd >> (16 * (off / 2))) & 32'hFFFF;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // One complete access: gd cycles before grant, rd WAIT cycles before rvalid.
    task automatic access(input string tag, input bit we, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int gd, input int rd, input logic [31:0] rdata);
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        tick();
        req_valid = 1'b0;
        if (!legal(size, addr)) begin
            chk({tag, ".ill_req"}, 32'(mem_req), 32'd0);
            chk({tag, ".ill_rsp"}, {30'd0, rsp_valid, rsp_err}, 32'd3);
            chk({tag, ".ill_rdata"}, rsp_rdata, 32'd0);
        end else begin
            for (int i = 0; i < gd && i < TO; i++) begin
                chk({tag, ".req_hold"}, 32'(mem_req), 32'd1);
                chk({tag, ".addr_hold"}, mem_addr, addr & ~32'd3);
                tick();
            end
            if (gd >= TO) begin
                chk({tag, ".to_req"}, 32'(mem_req), 32'd0);
                chk({tag, ".to_rsp"}, {30'd0, rsp_valid, rsp_err}, 32'd3);
                chk({tag, ".to_ready"}, 32'(req_ready), 32'd1);
            end else begin
                chk({tag, ".req"}, 32'(mem_req), 32'd1);
                chk({tag, ".we"}, 32'(mem_we), 32'(we));
                chk({tag, ".be"}, 32'(mem_be), 32'(m_be(size, addr)));
                chk({tag, ".addr"}, mem_addr, addr & ~32'd3);
                if (we) chk({tag, ".wdata"}, mem_wdata, m_wd(size, wd));
                mem_gnt = 1'b1;
                tick();
                mem_gnt = 1'b0;
                if (we) begin
                    chk({tag, ".st_rsp"}, {30'd0, rsp_valid, rsp_err}, 32'd2);
                    chk({tag, ".st_rdata"}, rsp_rdata, 32'd0);
                end else begin
                    for (int i = 0; i < rd && i < TO; i++) begin
                        chk({tag, ".wait"}, {30'd0, mem_req, rsp_valid}, 32'd0);
                        tick();
                    end
                    if (rd >= TO) begin
                        chk({tag, ".wto_rsp"}, {30'd0, rsp_valid, rsp_err}, 32'd3);
                    end else begin
                        mem_rvalid = 1'b1; mem_rdata = rdata;
                        tick();
                        mem_rvalid = 1'b0;
                        chk({tag, ".ld_rsp"}, {30'd0, rsp_valid, rsp_err}, 32'd2);
                        chk({tag, ".ld_rdata"}, rsp_rdata, m_rd(size, uns, addr, rdata));
                    end
                end
            end
        end
        tick();
        chk({tag, ".rsp_once"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.outs", {26'd0, rsp_valid, rsp_err, mem_req, mem_we, 2'd0}, 32'd0);
        chk("rst.be", 32'(mem_be), 32'd0);
        chk("rst.addr", mem_addr, 32'd0);

        access("sw",  1, 2'd2, 0, 32'h104, 32'hDEADBEEF, 0, 0, 0);
        access("sb",  1, 2'd0, 0, 32'h103, 32'h000000AB, 0, 0, 0);
        access("sh",  1, 2'd1, 0, 32'h102, 32'h00001234, 1, 0, 0);
        access("lb",  0, 2'd0, 0, 32'h101, 32'h0, 0, 0, 32'h0000F000);
        access("lbu", 0, 2'd0, 1, 32'h101, 32'h0, 0, 1, 32'h0000F000);
        access("lh",  0, 2'd1, 0, 32'h102, 32'h0, 0, 0, 32'h80000000);
        access("lw_mis", 0, 2'd2, 0, 32'h102, 32'h0, 0, 0, 0);
        access("sh_mis", 1, 2'd1, 0, 32'h001, 32'h0, 0, 0, 0);
        access("ill_sz", 0, 2'd3, 0, 32'h100, 32'h0, 0, 0, 0);
        access("st_to", 1, 2'd2, 0, 32'h200, 32'h1, TO, 0, 0);
        access("ld_to", 0, 2'd2, 0, 32'h200, 32'h0, 0, TO, 32'h1);
        access("ld_late", 0, 2'd2, 0, 32'h204, 32'h0, TO - 1, TO - 1, 32'h12345678);

        // Stray gnt/rvalid while idle must not start or finish anything.
        mem_gnt = 1'b1; mem_rvalid = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        chk("stray", {29'd0, req_ready, rsp_valid, mem_req}, 32'd4);

        // Reset while waiting for read data; the late rvalid is dropped.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h300;
        tick();
        req_valid = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw.outs", {28'd0, req_ready, rsp_valid, mem_req, rsp_err}, 32'd8);
        chk("rstw.addr", mem_addr, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
        tick();
        mem_rvalid = 1'b0;
        chk("rstw.late", {29'd0, req_ready, rsp_valid, mem_req}, 32'd4);

        for (int n = 0; n < 60; n++) begin
            logic [1:0] sz = 2'($urandom_range(0, 3));
            logic [31:0] a = $urandom & 32'h0000_FFFF;
            int gd = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, 2));
            int rd = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0 && sz == 2'd2) a = a & ~32'd3;
            access("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                   a, $urandom, gd, rd, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog expired");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
